// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - FSM states, oversampling constants and baud table for uart_receiver
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_EARLY = 7;
  localparam int TICK_MID   = 8;
  localparam int TICK_LATE  = 9;
  localparam int DIV_W      = 16;

  localparam int BAUD_TABLE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Rounded clk count between sample ticks for a rate code
  function automatic int div_of(input int clk_hz, input logic [2:0] code);
    int baud;
    baud = BAUD_TABLE[code];
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversample tick generator; i_restart realigns the divisor phase
module uart_rx_sampler
  import uart_receiver_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_rate,
  input  logic       i_restart,
  output logic       o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic [DIV_W-1:0] w_div_m1;

  assign w_div_m1 = DIV_W'(div_of(CLK_HZ, i_rate) - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt >= w_div_m1) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8-bit UART receiver, 16x oversampled with 2-of-3 mid-bit majority
// UART_RX_PARITY_EN adds an even parity bit to the frame and enables Rx_PERROR.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       RxD,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR
);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif
  localparam logic [3:0] POS_LAST_DATA = 4'd8;

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [1:0] r_sync;
  logic       r_rx_prev;
  logic [2:0] r_rate;
  logic [3:0] r_tick_cnt;
  logic [3:0] r_bit_pos;
  logic       r_s7;
  logic       r_s8;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ferror;

  logic       w_rx;
  logic       w_fall;
  logic       w_tick;
  logic [4:0] w_tick_idx;
  logic       w_bit_take;
  logic       w_bit_val;
  logic       w_start;
  logic       w_take_data;
  logic       w_stop_eval;
  logic       w_par_bad;

  uart_rx_sampler #(
    .CLK_HZ (CLK_HZ)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .i_rate    (r_rate),
    .i_restart (w_start),
    .o_tick    (w_tick)
  );

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_prev & ~w_rx;
  assign w_tick_idx = {1'b0, r_tick_cnt} + 5'd1;
  assign w_bit_take = w_tick & (w_tick_idx == 5'(TICK_LATE));
  assign w_bit_val  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], RxD};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_take_par;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take_data = 1'b0;
    w_stop_eval = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_take_par  = 1'b0;
`endif
    if (!Rx_EN) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_start     = 1'b1;
            w_state_nxt = ST_START;
          end
        end
        ST_START: begin
          if (w_tick && w_tick_idx == 5'(TICK_MID)) begin
            w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          // Position 0 is the tail of the start bit, which has no data to take
          if (w_bit_take && r_bit_pos != 4'd0) begin
            w_take_data = 1'b1;
            if (r_bit_pos == POS_LAST_DATA) begin
              w_state_nxt = ST_AFTER_DATA;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_take) begin
            w_take_par  = 1'b1;
            w_state_nxt = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_take) begin
            w_stop_eval = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rate     <= 3'd0;
      r_tick_cnt <= 4'd0;
      r_bit_pos  <= 4'd0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_ferror   <= 1'b0;
    end else begin
      r_valid  <= w_stop_eval & w_bit_val & ~w_par_bad;
      r_ferror <= w_stop_eval & ~w_bit_val;
      if (w_start) begin
        r_rate <= baud_select;
      end
      // Tick and bit-position counters run across state changes within a frame
      if (w_start || w_state_nxt == ST_IDLE) begin
        r_tick_cnt <= 4'd0;
        r_bit_pos  <= 4'd0;
      end else if (w_tick) begin
        if (w_tick_idx == 5'(OVERSAMPLE)) begin
          r_tick_cnt <= 4'd0;
          r_bit_pos  <= r_bit_pos + 4'd1;
        end else begin
          r_tick_cnt <= w_tick_idx[3:0];
        end
      end
      if (w_tick && w_tick_idx == 5'(TICK_EARLY)) begin
        r_s7 <= w_rx;
      end
      if (w_tick && w_tick_idx == 5'(TICK_MID)) begin
        r_s8 <= w_rx;
      end
      if (w_take_data) begin
        r_shift <= {w_bit_val, r_shift[7:1]};
      end
      if (w_stop_eval && w_bit_val) begin
        r_data <= r_shift;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_perror;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par    <= 1'b0;
      r_perror <= 1'b0;
    end else begin
      if (w_take_par) begin
        r_par <= w_bit_val;
      end
      r_perror <= w_stop_eval & w_bit_val & w_par_bad;
    end
  end

  assign w_par_bad = r_par ^ (^r_shift);
  assign Rx_PERROR = r_perror;
`else
  assign w_par_bad = 1'b0;
  assign Rx_PERROR = 1'b0;
`endif

  assign Rx_DATA   = r_data;
  assign Rx_VALID  = r_valid;
  assign Rx_FERROR = r_ferror;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed and random frame checks of uart_receiver against a frame-level model
module tb_uart_receiver;

  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       RxD;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  int n_multi  = 0;
  int valid_cyc[$];
  logic [7:0] valid_data[$];
  logic [7:0] exp_data;
  int stop_start_cyc;

  uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .RxD         (RxD),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_PERROR   (Rx_PERROR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (Rx_VALID) begin
      n_valid++;
      valid_cyc.push_back(cyc);
      valid_data.push_back(Rx_DATA);
    end
    if (Rx_FERROR) n_ferr++;
    if (Rx_PERROR) n_perr++;
    if (int'(Rx_VALID) + int'(Rx_FERROR) + int'(Rx_PERROR) > 1) n_multi++;
  end

  function automatic int bit_clks(input logic [2:0] code);
    int b;
    b = BAUD[code];
    return 16 * ((CLK_HZ + 8 * b) / (16 * b));
  endfunction

  function automatic bit near_mid(input int t, input int stop_start, input int bp);
    int mid;
    mid = stop_start + bp / 2;
    return (t > mid - bp) && (t < mid + bp);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int bp);
    RxD = v;
    wait_clks(bp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v,
                            input logic [2:0] code, input logic scramble, input int en_drop);
    int bp;
    bp = bit_clks(code);
    baud_select = code;
    drive_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) begin
      if (scramble && i == 2) baud_select = 3'($urandom_range(7, 0));
      if (i == en_drop) Rx_EN = 1'b0;
      drive_bit(d[i], bp);
    end
    if (PAR_EN) drive_bit((^d) ^ flip, bp);
    stop_start_cyc = cyc;
    drive_bit(stop_v, bp);
  endtask

  // Frame-level reference: stop low -> framing error, data kept; else parity
  // error (if parity is in the frame and was corrupted) or valid, data updated.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic flip,
                           input logic stop_v, input logic [2:0] code, input logic scramble);
    int v0, f0, p0, q0, bp;
    logic ev, ef, ep;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; q0 = valid_cyc.size();
    bp = bit_clks(code);
    send_frame(d, flip, stop_v, code, scramble, -1);
    ef = ~stop_v;
    ep = stop_v & PAR_EN & flip;
    ev = stop_v & ~ep;
    if (stop_v) exp_data = d;
    chk({tag, ".valid"}, n_valid - v0, int'(ev));
    chk({tag, ".ferror"}, n_ferr - f0, int'(ef));
    chk({tag, ".perror"}, n_perr - p0, int'(ep));
    chk({tag, ".data"}, int'(Rx_DATA), int'(exp_data));
    if (valid_cyc.size() > q0)
      chk({tag, ".when"}, int'(near_mid(valid_cyc[q0], stop_start_cyc, bp)), 1);
    RxD = 1'b1;
    wait_clks(2 * bp);
  endtask

  initial begin
    int v0, f0, p0, q0, bp, s1, s2;
    logic [7:0] d;
    logic [2:0] code;
    logic flip, stop_v;

    reset = 1'b0; RxD = 1'b1; Rx_EN = 1'b1; baud_select = 3'd0;
    exp_data = 8'h00;
    wait_clks(5);
    chk("reset.data", int'(Rx_DATA), 8'h00);
    chk("reset.valid", int'(Rx_VALID), 0);
    chk("reset.ferror", int'(Rx_FERROR), 0);
    chk("reset.perror", int'(Rx_PERROR), 0);
    reset = 1'b1;
    wait_clks(10);

    run_frame("a5_115200", 8'hA5, 1'b0, 1'b1, 3'd7, 1'b0);
    run_frame("3c_9600_par", 8'h3C, 1'b1, 1'b1, 3'd3, 1'b1);
    run_frame("55_stop0", 8'h55, 1'b0, 1'b0, 3'd7, 1'b0);

    // Short low glitch well before mid start bit
    bp = bit_clks(3'd7);
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    baud_select = 3'd7;
    RxD = 1'b0;
    wait_clks((bp * 100) / 432);
    RxD = 1'b1;
    wait_clks(14 * bp);
    chk("glitch.pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    run_frame("01_after_glitch", 8'h01, 1'b0, 1'b1, 3'd7, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    baud_select = 3'd7;
    drive_bit(1'b0, bp);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, bp);
    RxD = 1'b1;
    wait_clks(bp / 2);
    reset = 1'b0;
    wait_clks(2);
    chk("midrst.data", int'(Rx_DATA), 8'h00);
    chk("midrst.valid", int'(Rx_VALID), 0);
    reset = 1'b1;
    exp_data = 8'h00;
    wait_clks(12 * bp);
    chk("midrst.pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    run_frame("0f_after_rst", 8'h0F, 1'b0, 1'b1, 3'd7, 1'b0);

    // Back-to-back at 57600
    bp = bit_clks(3'd6);
    v0 = n_valid; q0 = valid_cyc.size();
    send_frame(8'h12, 1'b0, 1'b1, 3'd6, 1'b0, -1);
    s1 = stop_start_cyc;
    send_frame(8'h34, 1'b0, 1'b1, 3'd6, 1'b0, -1);
    s2 = stop_start_cyc;
    chk("b2b.count", n_valid - v0, 2);
    if (valid_cyc.size() >= q0 + 2) begin
      chk("b2b.data1", int'(valid_data[q0]), 8'h12);
      chk("b2b.data2", int'(valid_data[q0 + 1]), 8'h34);
      chk("b2b.when1", int'(near_mid(valid_cyc[q0], s1, bp)), 1);
      chk("b2b.when2", int'(near_mid(valid_cyc[q0 + 1], s2, bp)), 1);
    end
    exp_data = 8'h34;
    wait_clks(2 * bp);

    // Receiver disabled mid-frame
    bp = bit_clks(3'd7);
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'hC3, 1'b0, 1'b1, 3'd7, 1'b0, 3);
    wait_clks(2 * bp);
    Rx_EN = 1'b1;
    wait_clks(2 * bp);
    chk("en_abort.pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    chk("en_abort.data", int'(Rx_DATA), int'(exp_data));

    // Line stuck low: one framing error, then silence
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    baud_select = 3'd7;
    RxD = 1'b0;
    wait_clks(30 * bp);
    chk("stuck.ferror", n_ferr - f0, 1);
    chk("stuck.other", (n_valid - v0) + (n_perr - p0), 0);
    chk("stuck.data", int'(Rx_DATA), int'(exp_data));
    RxD = 1'b1;
    wait_clks(4 * bp);
    chk("stuck.after", n_ferr - f0, 1);
    run_frame("after_stuck", 8'h96, 1'b0, 1'b1, 3'd7, 1'b0);

    for (int k = 0; k < 10; k++) begin
      d      = 8'($urandom_range(255, 0));
      code   = 3'(5 + $urandom_range(2, 0));
      flip   = ($urandom_range(3, 0) == 0);
      stop_v = ($urandom_range(3, 0) != 0);
      run_frame($sformatf("rand%0d", k), d, flip, stop_v, code, 1'b1);
    end

    chk("one_pulse_per_clk", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLK_HZ, 50_000_000, system clock frequency in Hz, used to derive the sample divisors.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: baud_select  input  3  rate code, same encoding as the transmitter.
REQ-005 Port: RxD  input  1  serial line, asynchronous to clk, idle high.
REQ-006 Port: Rx_EN  input  1  receiver enable; low forces IDLE.
REQ-007 Port: Rx_DATA  output  8  last received byte.
REQ-008 Port: Rx_VALID  output  1  one-clk pulse: error-free frame delivered.
REQ-009 Port: Rx_FERROR  output  1  one-clk pulse: stop bit sampled low.
REQ-010 Port: Rx_PERROR  output  1  one-clk pulse: parity mismatch.

Function
REQ-011 Sample tick SHALL pulse for one clk every DIV clks, where DIV = round(CLK_HZ/(16*baud)).
REQ-012 Rate codes SHALL map 000..111 to 300, 1200, 4800, 9600, 19200, 38400, 57600 and 115200 baud; DIV at 50 MHz SHALL be 10417, 2604, 651, 326, 163, 81, 54 and 27.
REQ-013 RxD SHALL pass through a 2-flop synchronizer before any use; synchronizer reset value is 1.
REQ-014 Frame format SHALL be: start (0), 8 data bits LSB first, even parity bit, stop (1).
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-016 IDLE->START SHALL occur on a synchronized 1->0 transition while Rx_EN=1; baud_select SHALL be latched at this point and held for the whole frame.
REQ-017 START: at tick 8, line low -> DATA; line high -> IDLE (false start, no output pulse).
REQ-018 Each data, parity and stop bit SHALL be taken as the 2-of-3 majority of ticks 7, 8 and 9 within its 16-tick bit period.
REQ-019 DATA->PARITY SHALL occur after bit 7 is taken; PARITY->STOP after the parity bit is taken.
REQ-020 STOP: evaluation SHALL happen at tick 9 of the stop bit, followed by return to IDLE in the same cycle.
REQ-021 At STOP evaluation, Rx_DATA SHALL be updated whenever the stop bit is high, even when Rx_PERROR is reported.
REQ-022 At STOP evaluation, exactly one of Rx_VALID, Rx_FERROR or Rx_PERROR SHALL pulse.
REQ-023 When the stop bit is low, Rx_FERROR SHALL pulse and Rx_DATA SHALL hold its previous value.
REQ-024 Rx_DATA SHALL hold between frames.
REQ-025 Back-to-back frames SHALL be received with no idle time beyond the stop bit.
REQ-026 Rx_EN deasserted mid-frame SHALL abort to IDLE on the next clk with no output pulse; Rx_DATA is retained.
REQ-027 A baud_select change mid-frame SHALL NOT affect the frame in progress.
REQ-028 A line that is held low continuously SHALL produce one Rx_FERROR, then no further frame until a 1->0 edge is seen.

Reset
REQ-029 With reset low: state=IDLE, counters=0, Rx_DATA=8'h00, Rx_VALID=Rx_FERROR=Rx_PERROR=0, and latched rate = 000.
REQ-030 Reset asserted mid-frame SHALL discard the frame immediately; reception restarts only on a fresh 1->0 edge after reset release.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the frame contains the parity bit, it is checked, and Rx_PERROR is live.
REQ-032 Macro UART_RX_PARITY_EN undefined: PARITY state is absent, DATA->STOP directly, and Rx_PERROR is tied 0.
REQ-033 The transmitter SHALL be built with the matching setting.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the oversample constant (16), the mid-bit tick indices (7/8/9) and the rate-code-to-baud table.
REQ-035 One sub-module, uart_rx_sampler (rate code in, one-clk tick out, restart input), SHALL generate the tick; the restart input SHALL realign the divisor phase on start detection.

Verification
REQ-036 115200 baud (bit = 432 clk), frame 8'hA5 with parity 0 -> Rx_VALID one clk, Rx_DATA=8'hA5, no error pulses.
REQ-037 9600 baud, frame 8'h3C with parity bit forced 1 -> Rx_PERROR pulse, Rx_DATA=8'h3C, no Rx_VALID.
REQ-038 Frame 8'h55 with stop bit forced 0 -> Rx_FERROR pulse, Rx_DATA unchanged from the prior value.
REQ-039 Low glitch of 100 clk at 115200 -> return to IDLE, no pulses; then frame 8'h01 -> Rx_VALID with Rx_DATA=8'h01.
REQ-040 Reset pulse during DATA bit 4 of frame 8'hFF -> outputs at reset values, no pulse; next frame 8'h0F -> Rx_VALID with Rx_DATA=8'h0F.
REQ-041 Frames 8'h12 and 8'h34 sent back-to-back at 57600 -> two Rx_VALID pulses with the correct data, each within 1 bit period of its stop-bit midpoint.
